resp_demux2_pe: RTL and testbench
=================================

Name: resp_demux2_pe

Overview:
Response-path companion of the 2-input peripheral request mux. It records which of two initiator channels (CH0/CH1) owned each request accepted by the shared slave port. It then routes the in-order slave responses (valid, rdata, opc, ID) back to the originating channel through one register stage. It also gives the request mux a full indication so that outstanding transactions never exceed tracker capacity.

Parameters:
DATA_WIDTH, 32, response data width
ID_WIDTH, 20, response ID width, passed through unchanged
MAX_OUTSTANDING, 4, tracker depth; power of two, >=2
CNT_WIDTH, $clog2(MAX_OUTSTANDING+1), width of outstanding count

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req_acc_CH0_i  in  1  CH0 request accepted this cycle (req & gnt at slave port)
req_acc_CH1_i  in  1  CH1 request accepted this cycle
r_valid_i  in  1  slave response valid (single-cycle, in request order)
r_rdata_i  in  DATA_WIDTH  slave response data
r_opc_i  in  1  slave response error flag
r_ID_i  in  ID_WIDTH  slave response ID
r_valid_CH0_o  out  1  response valid to CH0
r_rdata_CH0_o  out  DATA_WIDTH  response data to CH0
r_opc_CH0_o  out  1  response error to CH0
r_ID_CH0_o  out  ID_WIDTH  response ID to CH0
r_valid_CH1_o, r_rdata_CH1_o, r_opc_CH1_o, r_ID_CH1_o  out  same widths and meanings, for CH1
tracker_full_o  out  1  combinational; 1 when count==MAX_OUTSTANDING. Upstream mux must suppress grants while it is 1.
outstanding_o  out  CNT_WIDTH  current tracker count (registered)
err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst=1 at clk edge): FIFO empty, read/write pointers 0, count 0. All outputs 0: valids, data, opc, ID, err_o. tracker_full_o=0.
- Tracker: FIFO of 1-bit channel tags, MAX_OUTSTANDING entries. Pointers wrap modulo MAX_OUTSTANDING.
- Push: exactly one req_acc asserted -> push tag (0=CH0, 1=CH1) at write pointer.
- Both req_acc asserted in the same cycle: no push; err_o<=1.
- Push when count==MAX_OUTSTANDING and no pop in that cycle: push dropped; err_o<=1.
- Push and pop in the same cycle with count==MAX_OUTSTANDING: both performed; count unchanged.
- Pop: r_valid_i=1 and count>0 -> pop the head tag.
- On pop, the next cycle drives r_valid_CHx_o=1 for the tagged channel. r_rdata/r_opc/r_ID_CHx_o take the registered r_*_i values. Latency is exactly 1 cycle.
- r_valid_i=1 with count==0: response dropped; no valid output; err_o<=1. A tag pushed in the same cycle is not visible to this pop (minimum request-to-response latency is 1 cycle).
- Valid outputs are single-cycle pulses. At most one of r_valid_CH0_o/r_valid_CH1_o is high per cycle.
- A channel's data/opc/ID outputs update only in cycles when that channel receives a valid response; otherwise they hold their last value.
- Count: +1 on push only, -1 on pop only, unchanged on both or neither. outstanding_o reflects the count after the edge.
- err_o: set by any error condition above; cleared only by rst.
- Reset mid-operation: all tags discarded and outputs forced to 0 in the following cycle. A response arriving after reset with count==0 is treated as spurious.

Test Plan:
1. Assert rst for 2 cycles, then release -> all outputs 0, outstanding_o=0, tracker_full_o=0, err_o=0.
2. Pulse req_acc CH0, CH1, CH0 in cycles 1-3. Send r_valid_i with rdata 0xA0, 0xA1, 0xA2 in cycles 5-7 -> r_valid_CH0_o with 0xA0 in cycle 6, r_valid_CH1_o with 0xA1 in cycle 7, r_valid_CH0_o with 0xA2 in cycle 8. outstanding_o goes 1,2,3 then 2,1,0. err_o stays 0.
3. With MAX_OUTSTANDING=4, issue 4 CH1 accepts -> tracker_full_o=1, outstanding_o=4. A 5th accept with no response -> err_o=1, outstanding_o stays 4.
4. Tracker full; in one cycle assert req_acc_CH0_i together with r_valid_i (rdata 0x55, opc=1) -> head CH1 gets 0x55/opc=1 next cycle, outstanding_o stays 4, err_o stays 0. The new CH0 tag is returned after the 4 earlier entries.
5. Empty tracker, assert r_valid_i with rdata 0x77 -> no valid output on either channel, err_o=1. Assert req_acc_CH0_i and req_acc_CH1_i together -> no push, err_o stays 1.
6. Run 12 cycles of alternating push/pop with tags CH0,CH1,CH1,CH0,... to force pointer wrap -> every response lands on its tag's channel in order. Then assert rst with 2 entries outstanding -> outstanding_o=0, and the next r_valid_i is dropped with err_o=1.

Source files
------------

// File: rtl/resp_demux2_pe.sv
// Response demux for the 2-input peripheral mux: tracks request ownership in a
// tag FIFO and steers in-order slave responses back to CH0/CH1 one cycle later.
module resp_demux2_pe #(
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 20,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_acc_CH0_i,
    input  logic                  req_acc_CH1_i,
    input  logic                  r_valid_i,
    input  logic [DATA_WIDTH-1:0] r_rdata_i,
    input  logic                  r_opc_i,
    input  logic [ID_WIDTH-1:0]   r_ID_i,
    output logic                  r_valid_CH0_o,
    output logic [DATA_WIDTH-1:0] r_rdata_CH0_o,
    output logic                  r_opc_CH0_o,
    output logic [ID_WIDTH-1:0]   r_ID_CH0_o,
    output logic                  r_valid_CH1_o,
    output logic [DATA_WIDTH-1:0] r_rdata_CH1_o,
    output logic                  r_opc_CH1_o,
    output logic [ID_WIDTH-1:0]   r_ID_CH1_o,
    output logic                  tracker_full_o,
    output logic [CNT_WIDTH-1:0]  outstanding_o,
    output logic                  err_o
);

    localparam int PTR_WIDTH = $clog2(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(MAX_OUTSTANDING);

    logic [MAX_OUTSTANDING-1:0] tag_mem;
    logic [PTR_WIDTH-1:0]       wr_ptr;
    logic [PTR_WIDTH-1:0]       rd_ptr;
    logic [CNT_WIDTH-1:0]       count;
    logic                       err;

    logic one_req;
    logic both_req;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic head_tag;
    logic err_set;

    // A pop frees a slot in the same cycle, so a push into a full tracker is
    // only legal when a response retires alongside it.
    always_comb begin
        one_req  = req_acc_CH0_i ^ req_acc_CH1_i;
        both_req = req_acc_CH0_i & req_acc_CH1_i;
        full     = (count == FULL_COUNT);
        empty    = (count == '0);
        pop      = r_valid_i & ~empty;
        push     = one_req & (~full | pop);
        head_tag = tag_mem[rd_ptr];
        err_set  = both_req
                 | (one_req & full & ~pop)
                 | (r_valid_i & empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_mem <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err     <= 1'b0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= req_acc_CH1_i;
                wr_ptr          <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // Each channel's payload registers load only on its own response and hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_CH0_o <= 1'b0;
            r_rdata_CH0_o <= '0;
            r_opc_CH0_o   <= 1'b0;
            r_ID_CH0_o    <= '0;
            r_valid_CH1_o <= 1'b0;
            r_rdata_CH1_o <= '0;
            r_opc_CH1_o   <= 1'b0;
            r_ID_CH1_o    <= '0;
        end else begin
            r_valid_CH0_o <= pop & ~head_tag;
            r_valid_CH1_o <= pop & head_tag;
            if (pop && !head_tag) begin
                r_rdata_CH0_o <= r_rdata_i;
                r_opc_CH0_o   <= r_opc_i;
                r_ID_CH0_o    <= r_ID_i;
            end
            if (pop && head_tag) begin
                r_rdata_CH1_o <= r_rdata_i;
                r_opc_CH1_o   <= r_opc_i;
                r_ID_CH1_o    <= r_ID_i;
            end
        end
    end

    assign tracker_full_o = full;
    assign outstanding_o  = count;
    assign err_o          = err;

    valid_onehot_a: assert property (@(posedge clk) !(r_valid_CH0_o && r_valid_CH1_o));
    count_bound_a:  assert property (@(posedge clk) disable iff (rst) count <= FULL_COUNT);

endmodule

// File: tb/tb_resp_demux2_pe.sv
// Scoreboard bench for resp_demux2_pe: a queue-based ownership model predicts
// responses; a monitor pops and compares them as the DUT presents valids.
module tb_resp_demux2_pe;

    localparam int DW  = 32;
    localparam int IW  = 20;
    localparam int MAX = 4;
    localparam int CW  = $clog2(MAX + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_acc_CH0 = 1'b0;
    logic          req_acc_CH1 = 1'b0;
    logic          r_valid = 1'b0;
    logic [DW-1:0] r_rdata = '0;
    logic          r_opc = 1'b0;
    logic [IW-1:0] r_ID = '0;
    logic          r_valid_CH0, r_valid_CH1;
    logic [DW-1:0] r_rdata_CH0, r_rdata_CH1;
    logic          r_opc_CH0, r_opc_CH1;
    logic [IW-1:0] r_ID_CH0, r_ID_CH1;
    logic          tracker_full;
    logic [CW-1:0] outstanding;
    logic          err;

    resp_demux2_pe #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MAX)) dut (
        .clk(clk), .rst(rst),
        .req_acc_CH0_i(req_acc_CH0), .req_acc_CH1_i(req_acc_CH1),
        .r_valid_i(r_valid), .r_rdata_i(r_rdata), .r_opc_i(r_opc), .r_ID_i(r_ID),
        .r_valid_CH0_o(r_valid_CH0), .r_rdata_CH0_o(r_rdata_CH0),
        .r_opc_CH0_o(r_opc_CH0), .r_ID_CH0_o(r_ID_CH0),
        .r_valid_CH1_o(r_valid_CH1), .r_rdata_CH1_o(r_rdata_CH1),
        .r_opc_CH1_o(r_opc_CH1), .r_ID_CH1_o(r_ID_CH1),
        .tracker_full_o(tracker_full), .outstanding_o(outstanding), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            ch;
        logic [DW-1:0] data;
        logic          opc;
        logic [IW-1:0] id;
        int            due;
    } resp_t;

    resp_t         exp_q[$];
    bit            tag_q[$];
    logic          m_err = 1'b0;
    logic [DW-1:0] m_data[2] = '{'0, '0};
    logic          m_opc[2]  = '{1'b0, 1'b0};
    logic [IW-1:0] m_id[2]   = '{'0, '0};
    int            cyc = 0;
    int            checks = 0;
    int            passes = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req)
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        else
            passes++;
    endtask

    // Drives one cycle of inputs and advances the reference model to the post-edge state.
    task automatic applyStimulus(input bit r, input bit a0, input bit a1, input bit rv,
                                 input logic [DW-1:0] d, input logic o, input logic [IW-1:0] id);
        resp_t e;
        bit    tag;
        @(negedge clk);
        rst = r; req_acc_CH0 = a0; req_acc_CH1 = a1;
        r_valid = rv; r_rdata = d; r_opc = o; r_ID = id;
        if (r) begin
            tag_q.delete();
            m_err = 1'b0;
            for (int c = 0; c < 2; c++) begin
                m_data[c] = '0; m_opc[c] = 1'b0; m_id[c] = '0;
            end
        end else begin
            if (rv && tag_q.size() > 0) begin
                tag = tag_q.pop_front();
                e.ch = tag; e.data = d; e.opc = o; e.id = id; e.due = cyc + 1;
                exp_q.push_back(e);
                m_data[tag] = d; m_opc[tag] = o; m_id[tag] = id;
            end else if (rv) begin
                m_err = 1'b1;
            end
            if (a0 && a1) begin
                m_err = 1'b1;
            end else if (a0 || a1) begin
                if (tag_q.size() < MAX) tag_q.push_back(a1);
                else m_err = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, $urandom, 1'($urandom), IW'($urandom));
    endtask

    task automatic respond(input logic [DW-1:0] d, input logic o);
        applyStimulus(0, 0, 0, 1, d, o, IW'($urandom));
    endtask

    // Monitor: scoreboard matching plus per-cycle comparison of status and held payloads.
    initial begin
        resp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                checkOutput("missing_response", 0, 1);
                void'(exp_q.pop_front());
            end
            checkOutput("valid_onehot", 64'(r_valid_CH0 & r_valid_CH1), 0);
            if (r_valid_CH0 || r_valid_CH1) begin
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    e = exp_q.pop_front();
                    checkOutput("resp_channel", 64'(r_valid_CH1), 64'(e.ch));
                    checkOutput("resp_data", e.ch ? r_rdata_CH1 : r_rdata_CH0, e.data);
                    checkOutput("resp_opc", e.ch ? r_opc_CH1 : r_opc_CH0, 64'(e.opc));
                    checkOutput("resp_id", e.ch ? r_ID_CH1 : r_ID_CH0, e.id);
                end else begin
                    checkOutput("spurious_response", 1, 0);
                end
            end
            checkOutput("outstanding", outstanding, tag_q.size());
            checkOutput("tracker_full", 64'(tracker_full), 64'(tag_q.size() == MAX));
            checkOutput("err", 64'(err), 64'(m_err));
            checkOutput("hold_data_ch0", r_rdata_CH0, m_data[0]);
            checkOutput("hold_data_ch1", r_rdata_CH1, m_data[1]);
            checkOutput("hold_opc_ch0", 64'(r_opc_CH0), 64'(m_opc[0]));
            checkOutput("hold_opc_ch1", 64'(r_opc_CH1), 64'(m_opc[1]));
            checkOutput("hold_id_ch0", r_ID_CH0, m_id[0]);
            checkOutput("hold_id_ch1", r_ID_CH1, m_id[1]);
        end
    end

    initial begin
        bit a0, a1, rv, pat;
        int r;
        $display("[TB] start");
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        idle(1);

        // In-order return to mixed owners
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        idle(1);
        respond(32'hA0, 0);
        respond(32'hA1, 0);
        respond(32'hA2, 0);
        idle(2);

        // Fill to capacity, then overflow without a response
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        idle(1);

        // Simultaneous push and pop while full
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 32'h55, 1, 20'h12345);
        for (int i = 0; i < 4; i++) respond(32'hB0 + i, 0);
        idle(1);

        // Spurious response, then double accept
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        respond(32'h77, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        idle(1);

        // Alternating push/pop across pointer wrap, then reset with entries pending
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            pat = (i % 4 == 1) || (i % 4 == 2);
            applyStimulus(0, !pat, pat, 0, 0, 0, 0);
            respond($urandom, 1'($urandom));
        end
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        respond(32'hDEAD, 0);
        idle(1);

        // Randomised episodes with rare protocol errors
        for (int ep = 0; ep < 8; ep++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0);
            for (int i = 0; i < 60; i++) begin
                r  = $urandom_range(0, 31);
                a0 = 0; a1 = 0;
                if (r == 0) begin a0 = 1; a1 = 1; end
                else if (r < 12) a0 = 1;
                else if (r < 22) a1 = 1;
                if ((a0 ^ a1) && tag_q.size() == MAX && $urandom_range(0, 7) != 0) begin
                    a0 = 0; a1 = 0;
                end
                rv = ($urandom_range(0, 1) == 1);
                if (rv && tag_q.size() == 0 && $urandom_range(0, 7) != 0) rv = 0;
                applyStimulus(0, a0, a1, rv, $urandom, 1'($urandom), IW'($urandom));
            end
        end
        idle(3);

        @(posedge clk);
        #2;
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
